// File: rtl/dfd_cla_edge_chan_arb.sv
// rtl/dfd_cla_edge_chan_arb.sv - round-robin arbiter/sequencer for the two CLA edge-detect channels
// Optional delivered-edge statistics: define DFD_CLA_EDGE_ARB_STATS_EN.
module dfd_cla_edge_chan_arb #(
  parameter int NUM_REQ      = 4,
  parameter int SEL_W        = 6,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*SEL_W-1:0] req_sel,
  input  logic [NUM_REQ-1:0]       req_posedge,
  input  logic [NUM_REQ-1:0]       req_release,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       grant_chan,
  output logic [SEL_W-1:0]         cfg_signal0_select,
  output logic [SEL_W-1:0]         cfg_signal1_select,
  output logic                     cfg_posedge0,
  output logic                     cfg_posedge1,
  input  logic [1:0]               edge_in,
  output logic [NUM_REQ-1:0]       edge_out,
  output logic [15:0]              edge_cnt0,
  output logic [15:0]              edge_cnt1
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BLANK_CYCLES + 1);

  typedef enum logic [1:0] {CH_IDLE, CH_BLANK, CH_ACTIVE} ch_state_t;

  ch_state_t         ch_state  [2];
  logic [IW-1:0]     owner     [2];
  logic [BW-1:0]     blank_cnt [2];
  logic [IW-1:0]     rr_ptr;

  logic [NUM_REQ-1:0] eligible;
  logic [IW:0]        cand;
  logic               found;
  logic [IW-1:0]      win;
  logic [IW-1:0]      win_next;
  logic               any_idle;
  logic               alloc_chan;
  logic               alloc;
  logic [1:0]         rel;

  assign eligible = req_valid & ~grant;

  // Round-robin search for the first eligible requester starting at rr_ptr
  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!found && eligible[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
  end

  assign win_next   = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
  assign any_idle   = (ch_state[0] == CH_IDLE) || (ch_state[1] == CH_IDLE);
  assign alloc_chan = (ch_state[0] != CH_IDLE);
  assign alloc      = found && any_idle;

  // A release only counts when it comes from the current owner of a busy channel
  always_comb begin
    for (int c = 0; c < 2; c++)
      rel[c] = (ch_state[c] != CH_IDLE) && req_release[owner[c]];
  end

  // Channel FSMs, allocation, grants and channel configuration
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        ch_state[c]  <= CH_IDLE;
        owner[c]     <= '0;
        blank_cnt[c] <= '0;
      end
      rr_ptr             <= '0;
      grant              <= '0;
      grant_chan         <= '0;
      cfg_signal0_select <= '0;
      cfg_signal1_select <= '0;
      cfg_posedge0       <= 1'b0;
      cfg_posedge1       <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        case (ch_state[c])
          CH_BLANK: begin
            if (rel[c]) begin
              ch_state[c]  <= CH_IDLE;
              blank_cnt[c] <= '0;
            end else if (blank_cnt[c] == BW'(BLANK_CYCLES)) begin
              ch_state[c]  <= CH_ACTIVE;
            end else begin
              blank_cnt[c] <= blank_cnt[c] + BW'(1);
            end
          end
          CH_ACTIVE: begin
            if (rel[c]) begin
              ch_state[c]  <= CH_IDLE;
              blank_cnt[c] <= '0;
            end
          end
          default: ;
        endcase
        if (rel[c]) grant[owner[c]] <= 1'b0;
      end
      // The allocated channel is IDLE now, so it never collides with the FSM updates above
      if (alloc) begin
        ch_state[alloc_chan]  <= CH_BLANK;
        blank_cnt[alloc_chan] <= BW'(1);
        owner[alloc_chan]     <= win;
        grant[win]            <= 1'b1;
        grant_chan[win]       <= alloc_chan;
        rr_ptr                <= win_next;
        if (alloc_chan) begin
          cfg_signal1_select <= req_sel[win*SEL_W +: SEL_W];
          cfg_posedge1       <= req_posedge[win];
        end else begin
          cfg_signal0_select <= req_sel[win*SEL_W +: SEL_W];
          cfg_posedge0       <= req_posedge[win];
        end
      end
    end
  end

  // Route each ACTIVE channel's edge pulse to its owner; blanked pulses are dropped
  always_comb begin
    edge_out = '0;
    for (int c = 0; c < 2; c++) begin
      if (ch_state[c] == CH_ACTIVE)
        edge_out[owner[c]] = edge_out[owner[c]] | edge_in[c];
    end
  end

`ifdef DFD_CLA_EDGE_ARB_STATS_EN
  logic [15:0] stat_cnt [2];

  // Saturating delivered-edge counters, cleared when their channel is reallocated
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_cnt[0] <= '0;
      stat_cnt[1] <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (alloc && (alloc_chan == 1'(c)))
          stat_cnt[c] <= '0;
        else if ((ch_state[c] == CH_ACTIVE) && edge_in[c] && (stat_cnt[c] != 16'hFFFF))
          stat_cnt[c] <= stat_cnt[c] + 16'd1;
      end
    end
  end

  assign edge_cnt0 = stat_cnt[0];
  assign edge_cnt1 = stat_cnt[1];
`else
  assign edge_cnt0 = 16'd0;
  assign edge_cnt1 = 16'd0;
`endif

endmodule

// File: doc/dfd_cla_edge_chan_arb.md
# dfd_cla_edge_chan_arb

Arbiter and sequencer for the CLA's two debug-signal edge-detect channels. Up to NUM_REQ trigger requesters compete for channel 0/1. The block grants channels round-robin and drives the edge-detect select/polarity configuration for each granted channel. After each reconfiguration it blanks the channel's edge output until the edge detector's internal history has settled, then routes detected edges to the owning requester.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- SEL_W, 6, signal-select width (log2 of debug bus width)
- BLANK_CYCLES, 2, cycles of edge masking after a channel is (re)configured (≥1)

Ports:
- clock  in  1  block clock
- reset_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NUM_REQ  level request for a channel; held until grant seen
- req_sel  in  NUM_REQ*SEL_W  per-requester debug-bus bit select; slice r = [r*SEL_W +: SEL_W]
- req_posedge  in  NUM_REQ  per-requester polarity: 1 = rising, 0 = falling
- req_release  in  NUM_REQ  one-cycle pulse; the owner frees its channel
- grant  out  NUM_REQ  level; high while requester owns a channel
- grant_chan  out  NUM_REQ  channel index owned by requester r; valid only while grant[r]
- cfg_signal0_select / cfg_signal1_select  out  SEL_W each  select for channel 0/1
- cfg_posedge0 / cfg_posedge1  out  1 each  polarity for channel 0/1
- edge_in  in  2  edge-detect pulses, bit c = channel c
- edge_out  out  NUM_REQ  edge pulse routed to requester r
- edge_cnt0 / edge_cnt1  out  16 each  per-channel delivered-edge count (see Configuration)

## Operation
- Per-channel FSM: IDLE -> BLANK -> ACTIVE -> IDLE.
  - IDLE -> BLANK on allocation.
  - BLANK -> ACTIVE when the blank counter reaches BLANK_CYCLES.
  - BLANK or ACTIVE -> IDLE on req_release from the owner.
- Allocation:
  - At most one allocation per cycle.
  - Eligible requesters: req_valid=1 and grant=0.
  - Winner: first eligible requester searching upward from rr_ptr, modulo NUM_REQ.
  - Channel chosen: lowest-numbered IDLE channel.
  - No allocation if both channels are non-IDLE.
  - After an allocation, rr_ptr = winner+1 mod NUM_REQ.
- On allocation, the channel's cfg_signalN_select/cfg_posedgeN register req_sel/req_posedge of the winner, and owner[c] is recorded. Cfg outputs hold their value after release.
- Release:
  - A req_release from a requester without grant, or pulsed during allocation to a different requester, is ignored.
  - A released channel is IDLE the next cycle. It is allocatable only from that cycle on, never in the release cycle itself.
  - req_release on the same cycle the requester's grant would rise is ignored; the grant is still issued.
- Edge routing: edge_out[r] = edge_in[c] when channel c is ACTIVE and owner[c]==r. Otherwise 0. Combinational from edge_in.
- req_valid from a requester that already owns a channel is ignored; at most one channel per requester.

## Timing
- Reset (async, reset_n=0) values:
  - grant, grant_chan, edge_out, cfg_* = 0
  - channels IDLE, rr_ptr = 0, blank counters = 0, edge_cnt* = 0
- Reset mid-operation drops all grants immediately. No release handshake is needed.
- req_valid sampled at edge t (channel free):
  - grant/grant_chan/cfg_* update at t+1.
  - BLANK covers cycles t+1..t+BLANK_CYCLES.
  - ACTIVE from t+1+BLANK_CYCLES.
- Release sampled at edge t: grant drops at t+1 and edge_out is masked from t+1. A new allocation is sampled no earlier than edge t+1, so the new grant appears at t+2.
- edge_in pulses during BLANK are dropped, not delayed.

## Configuration
- DFD_CLA_EDGE_ARB_STATS_EN:
  - Defined: edge_cnt0/edge_cnt1 are 16-bit saturating counters of edge_out pulses delivered on channel 0/1. A counter clears to 0 on its channel's allocation and holds at 16'hFFFF.
  - Undefined: ports remain and are tied to 0; no counter flops.

## Test plan
- Reset then req_valid[2]=1, req_sel[2]=6'd17, req_posedge[2]=1 -> grant[2]=1, grant_chan[2]=0, cfg_signal0_select=17, cfg_posedge0=1 one cycle later. edge_in[0] pulses in the 2 BLANK cycles give edge_out=0; a pulse at the 3rd cycle gives edge_out[2]=1.
- req_valid=4'b1111 from reset -> requester 0 gets channel 0 at t+1, requester 1 gets channel 1 at t+2, requesters 2/3 stay ungranted. req_release[0] -> requester 2 granted channel 0 two cycles after the release.
- Release and a new request on the same cycle for a single free-channel scenario -> the new grant appears exactly 2 cycles after the release edge, never 1.
- req_release[3] pulsed while requester 3 has no grant -> no state change. req_valid held by an owner -> no second channel.
- reset_n asserted while both channels are ACTIVE -> grant=0 and edge_out=0 asynchronously, and cfg_*=0.
- With STATS_EN: 70000 edge_in[1] pulses on an ACTIVE channel -> edge_cnt1=16'hFFFF. Re-allocation -> edge_cnt1=0. Without STATS_EN -> edge_cnt*=0 throughout.
